// File: rtl/bcd_disp_pkg.sv
// -----------------------------------------------------------------------------
// bcd_disp_pkg
// Shared definitions for the multiplexed seven-segment display scanner.
//   - bcd_digit_t : one 4-bit BCD digit
//   - SEG_0..SEG_9, SEG_DASH, SEG_OFF : segment patterns, bit order {g,f,e,d,c,b,a},
//     active-high
//   - bcd_is_valid() : true for codes 0..9
// -----------------------------------------------------------------------------
package bcd_disp_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;  // middle bar only, shown for codes 10..15
  localparam logic [6:0] SEG_OFF  = 7'h00;

  function automatic logic bcd_is_valid(input bcd_digit_t d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// -----------------------------------------------------------------------------
// bcd_to_seg7
// Purely combinational BCD to seven-segment decoder. Codes 10..15 are not
// valid BCD and render as a dash so a bad digit is visible on the display.
// Ports:
//   digit_i : 4-bit BCD digit
//   seg_o   : segment pattern {g,f,e,d,c,b,a}, active-high
// -----------------------------------------------------------------------------
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// -----------------------------------------------------------------------------
// bcd_display_scanner
// Time-multiplexed seven-segment driver for a chain of BCD counters. A snapshot
// of the packed digits is taken on a load strobe; the snapshot is then scanned
// one digit per slot onto a shared segment bus with one-hot digit enables. The
// first cycle of every slot is dead (all enables and segments off) to suppress
// ghosting while the enables switch.
//
// Parameters:
//   DIGITS      : number of digits scanned (1..8)
//   REFRESH_DIV : clocks per digit slot (>= 2), 1 dead + REFRESH_DIV-1 lit
// Ports:
//   clk    : system clock, rising edge
//   clr    : asynchronous active-low reset
//   bcd_in : packed digits, digit i at bcd_in[4i+3:4i], digit 0 least significant
//   load   : capture strobe; bcd_in is only looked at on edges where load=1,
//            the producer raises it only once its ripple outputs have settled
//   seg    : segments {g,f,e,d,c,b,a}, active-high, registered
//   an     : one-hot digit enable, active-high, registered
//   err    : sticky flag, set when any captured digit is >9, cleared by clr
//
// Build option:
//   LEADING_ZERO_BLANK_EN : when defined, digits above the highest nonzero
//   digit of the snapshot are blanked (seg=0, an still asserted). Digit 0 is
//   never blanked. Undefined: all digits decode normally.
// -----------------------------------------------------------------------------
module bcd_display_scanner
  import bcd_disp_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  err
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // State
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]    idx_q,     idx_d;
  logic [4*DIGITS-1:0] snap_q,    snap_d;
  logic [6:0]          seg_q,     seg_d;
  logic [DIGITS-1:0]   an_q,      an_d;
  logic                err_q,     err_d;

  // Combinational helpers
  logic       div_wrap;
  logic       cap_bad;
  bcd_digit_t cur_digit;
  logic [6:0] dec_seg;
  logic       blank;

  // Next state. Outputs are computed from the *next* divider, index and
  // snapshot so that, after each edge, seg/an match that cycle's state
  // without an extra pipeline stage.
  always_comb begin
    div_wrap  = (div_cnt_q == DIV_LAST);
    div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;

    idx_d = idx_q;
    if (div_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    snap_d = load ? bcd_in : snap_q;

    cap_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (load && !bcd_is_valid(bcd_in[4*i +: 4])) begin
        cap_bad = 1'b1;
      end
    end
    err_d = err_q | cap_bad;

    // Digit under the scan this coming cycle, and its one-hot enable.
    cur_digit = '0;
    an_d      = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        cur_digit = snap_d[4*i +: 4];
        an_d[i]   = 1'b1;
      end
    end
    if (div_cnt_d == '0) begin
      an_d = '0;
    end
  end

  // Leading-zero blanking: find the highest nonzero digit of the snapshot
  // being displayed; anything above it is dark. Invalid codes count as nonzero.
`ifdef LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] hi_nz;

  always_comb begin
    hi_nz = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (snap_d[4*i +: 4] != 4'd0) begin
        hi_nz = IDX_W'(i);
      end
    end
    blank = (idx_d > hi_nz);
  end
`else
  assign blank = 1'b0;
`endif

  bcd_to_seg7 u_dec (
    .digit_i (cur_digit),
    .seg_o   (dec_seg)
  );

  always_comb begin
    seg_d = dec_seg;
    if (div_cnt_d == '0 || blank) begin
      seg_d = SEG_OFF;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      div_cnt_q <= '0;
      idx_q     <= '0;
      snap_q    <= '0;
      seg_q     <= SEG_OFF;
      an_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      err_q     <= err_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign err = err_q;

endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

Multiplexed seven-segment display driver that sits directly downstream of the MOD-10 ripple counter chain. It captures a packed vector of BCD digits on a load strobe and time-multiplexes them onto one shared segment bus with one-hot digit enables. It blanks digits between slots to suppress ghosting and flags invalid BCD codes.

## Interface
- DIGITS, 4, number of BCD digits scanned (1..8)
- REFRESH_DIV, 1000, clocks per digit slot (>= 2)
- clk  input  1  system clock, rising-edge
- clr  input  1  reset, asynchronous, active-low
- bcd_in  input  4*DIGITS  packed digits, digit i at bcd_in[4i+3:4i], digit 0 = least significant
- load  input  1  capture strobe, sampled on rising clk
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high, registered
- an  output  DIGITS  one-hot digit enable, active-high, registered
- err  output  1  sticky invalid-BCD flag, registered

## Operation
- Snapshot register: on an edge with load=1, snap <= bcd_in; otherwise it holds. The scanner never reads bcd_in directly, because upstream ripple outputs settle asynchronously and the producer asserts load only when they are stable.
- Divider div_cnt counts 0..REFRESH_DIV-1 and wraps to 0. When it wraps, idx advances idx+1 and wraps DIGITS-1 -> 0.
- Dead time: while div_cnt==0, an=0 and seg=0. At all other counts, an=onehot(idx) and seg=decode(snap digit idx).
- Decode: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F (hex). Codes 10..15 display 40 (dash).
- err: set on any capture edge where any captured digit >9. It is sticky and cleared only by clr.
- Outputs are flops loaded from next-state values, so in any cycle seg/an correspond to that cycle's div_cnt/idx/snap.
- Reset values: div_cnt=0, idx=0, snap=0, seg=0, an=0, err=0.

## Timing
- Slot length: REFRESH_DIV cycles, comprising 1 dead cycle and REFRESH_DIV-1 lit cycles. Full frame: DIGITS*REFRESH_DIV cycles.
- After clr deasserts, the first edge gives div_cnt=1, an=onehot(0), seg=3F (snap=0).
- Load latency: with load high at edge N, the new digit appears on seg at edge N, but only if that edge lands in a lit cycle of the affected digit. There are no extra pipeline stages.
- load held high: snap recaptures every edge. Mid-slot changes appear immediately; the scan timing is not disturbed.
- load on the same edge as the div_cnt wrap: both take effect; the new slot shows the new snapshot after its dead cycle.
- clr asserted mid-slot: all state and outputs clear immediately, asynchronously. Scanning restarts from idx=0.
- DIGITS=1: idx stays 0, and an pulses 0 for one cycle per slot.

## Configuration
- LEADING_ZERO_BLANK_EN defined: any digit above the highest nonzero digit of snap shows seg=0 with an still asserted. Digit 0 is always displayed, so a snap of all zeros shows "0" on digit 0 only. A digit >9 counts as nonzero.
- Undefined: every digit is decoded normally, including leading zeros.

## Structure
- Package bcd_disp_pkg holds the segment constants SEG_0..SEG_9, SEG_DASH, SEG_OFF, and the 4-bit BCD digit typedef.
- One sub-module, bcd_to_seg7: a combinational 4-bit to 7-bit decoder including the dash for invalid codes. The top module holds the divider, index, snapshot, blanking, err and output flops.

## Test plan
- Reset/scan: DIGITS=4, REFRESH_DIV=4, clr released, load pulsed with bcd_in=16'h1234 -> repeating an sequence 0,1,1,1,0,2,2,2,0,4,4,4,0,8,8,8 with seg 66,4F,5B,06 on digit slots 0..3.
- Invalid code: load bcd_in=16'h00A5 -> digit 1 shows 40, err=1 and stays 1 after a later load of 16'h0005. clr clears it to 0.
- Mid-scan reload: load 16'h0009 and then, during a digit-0 lit cycle, load 16'h0008 -> seg changes 6F->7F on that edge, and the an cadence is unchanged.
- Async reset: assert clr during a lit cycle of digit 2 -> an=0, seg=0, err=0 with no clock edge. After release, the scan restarts at digit 0.
- LEADING_ZERO_BLANK_EN defined: snap=16'h0040 -> digits 3 and 2 seg=00, digit 1 seg=66, digit 0 seg=3F. snap=16'h0000 -> only digit 0 shows 3F.
- Wrap plus load: load asserted exactly on the div_cnt 3->0 edge -> dead cycle (an=0), then the next digit shows the new value.
